// File: rtl/counter_checker.sv
// Shadow checker for an up-counter with load and enable: keeps a resynchronised
// expected value, flags each divergence, and records error statistics.
module counter_checker #(
   parameter int WIDTH       = 4,
   parameter int ERR_CNT_W   = 8,
   parameter bit STOP_ON_ERR = 1'b0
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 check_en_i,
   input  logic                 clear_i,
   input  logic                 cnt_en_i,
   input  logic                 cnt_load_i,
   input  logic [WIDTH-1:0]     cnt_data_i,
   input  logic [WIDTH-1:0]     cnt_q_i,
   output logic                 err_o,
   output logic                 err_sticky_o,
   output logic [ERR_CNT_W-1:0] err_cnt_o,
   output logic [WIDTH-1:0]     exp_o,
   output logic [WIDTH-1:0]     first_err_exp_o,
   output logic [WIDTH-1:0]     first_err_obs_o,
   output logic [1:0]           state_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_TRACK = 2'b01,
      ST_FAULT = 2'b10
   } state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     exp_q, exp_d;
   logic                 err_q, err_d;
   logic                 sticky_q, sticky_d;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [WIDTH-1:0]     first_exp_q, first_exp_d;
   logic [WIDTH-1:0]     first_obs_q, first_obs_d;
   logic [WIDTH-1:0]     next_val;

   // Reference model applied to the observed value, so one bad sample costs one error.
   always_comb begin
      if (cnt_load_i)    next_val = cnt_data_i;
      else if (cnt_en_i) next_val = cnt_q_i + WIDTH'(1);
      else               next_val = cnt_q_i;
   end

   always_comb begin
      // NOTE: every output of this block gets a default first so no path infers a latch.
      state_d     = state_q;
      exp_d       = exp_q;
      err_d       = 1'b0;
      sticky_d    = sticky_q;
      err_cnt_d   = err_cnt_q;
      first_exp_d = first_exp_q;
      first_obs_d = first_obs_q;

      if (clear_i) begin
         state_d     = ST_IDLE;
         exp_d       = next_val;
         sticky_d    = 1'b0;
         err_cnt_d   = '0;
         first_exp_d = '0;
         first_obs_d = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               exp_d = next_val;
               if (check_en_i) state_d = ST_TRACK;
            end
            ST_TRACK: begin
               exp_d = next_val;
               if (!check_en_i) begin
                  state_d = ST_IDLE;
               end else if (cnt_q_i != exp_q) begin
                  err_d    = 1'b1;
                  sticky_d = 1'b1;
                  if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
                  if (!sticky_q) begin
                     first_exp_d = exp_q;
                     first_obs_d = cnt_q_i;
                  end
                  if (STOP_ON_ERR) state_d = ST_FAULT;
               end
            end
            ST_FAULT: ;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= ST_IDLE;
         exp_q       <= '0;
         err_q       <= 1'b0;
         sticky_q    <= 1'b0;
         err_cnt_q   <= '0;
         first_exp_q <= '0;
         first_obs_q <= '0;
      end else begin
         state_q     <= state_d;
         exp_q       <= exp_d;
         err_q       <= err_d;
         sticky_q    <= sticky_d;
         err_cnt_q   <= err_cnt_d;
         first_exp_q <= first_exp_d;
         first_obs_q <= first_obs_d;
      end
   end

   assign err_o           = err_q;
   assign err_sticky_o    = sticky_q;
   assign err_cnt_o       = err_cnt_q;
   assign exp_o           = exp_q;
   assign first_err_exp_o = first_exp_q;
   assign first_err_obs_o = first_obs_q;
   assign state_o         = state_q;

endmodule

// File: tb/tb_counter_checker.sv
// Directed bench for counter_checker: a free-running sequence, a vector table,
// and hand-written saturation, reset and stop-on-error sequences.
module tb_counter_checker;

   logic       clk = 1'b1;
   logic       rst_n;
   logic       check_en, clear, cnt_en, cnt_load;
   logic [3:0] cnt_data, cnt_q;

   logic       err, sticky;
   logic [7:0] err_cnt;
   logic [3:0] exp_v, fexp, fobs;
   logic [1:0] state;

   logic       s_err, s_sticky;
   logic [7:0] s_err_cnt;
   logic [3:0] s_exp, s_fexp, s_fobs;
   logic [1:0] s_state;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   counter_checker #(.WIDTH(4), .ERR_CNT_W(8), .STOP_ON_ERR(1'b0)) u_dut (
      .clk_i(clk), .rst_n_i(rst_n), .check_en_i(check_en), .clear_i(clear),
      .cnt_en_i(cnt_en), .cnt_load_i(cnt_load), .cnt_data_i(cnt_data), .cnt_q_i(cnt_q),
      .err_o(err), .err_sticky_o(sticky), .err_cnt_o(err_cnt), .exp_o(exp_v),
      .first_err_exp_o(fexp), .first_err_obs_o(fobs), .state_o(state)
   );

   counter_checker #(.WIDTH(4), .ERR_CNT_W(8), .STOP_ON_ERR(1'b1)) u_stop (
      .clk_i(clk), .rst_n_i(rst_n), .check_en_i(check_en), .clear_i(clear),
      .cnt_en_i(cnt_en), .cnt_load_i(cnt_load), .cnt_data_i(cnt_data), .cnt_q_i(cnt_q),
      .err_o(s_err), .err_sticky_o(s_sticky), .err_cnt_o(s_err_cnt), .exp_o(s_exp),
      .first_err_exp_o(s_fexp), .first_err_obs_o(s_fobs), .state_o(s_state)
   );

   typedef struct {
      logic       ce, clr, en, ld;
      logic [3:0] data, q;
      logic       err;
      logic [3:0] exp_v;
      logic       sticky;
      logic [7:0] cnt;
      logic [1:0] state;
      logic [3:0] fexp, fobs;
   } vec_t;

   vec_t tbl [21];

   function automatic vec_t mk(input logic ce, clr, en, ld, input logic [3:0] data, q,
                               input logic e, input logic [3:0] x, input logic st,
                               input logic [7:0] c, input logic [1:0] s,
                               input logic [3:0] fe, fo);
      vec_t v;
      v.ce = ce; v.clr = clr; v.en = en; v.ld = ld; v.data = data; v.q = q;
      v.err = e; v.exp_v = x; v.sticky = st; v.cnt = c; v.state = s; v.fexp = fe; v.fobs = fo;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic drive(input logic ce, clr, en, ld, input logic [3:0] data, q);
      check_en = ce; clear = clr; cnt_en = en; cnt_load = ld; cnt_data = data; cnt_q = q;
   endtask

   task automatic edge_sample();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " err"},     err,     0);
      check({tag, " sticky"},  sticky,  0);
      check({tag, " err_cnt"}, err_cnt, 0);
      check({tag, " exp"},     exp_v,   0);
      check({tag, " fexp"},    fexp,    0);
      check({tag, " fobs"},    fobs,    0);
      check({tag, " state"},   state,   0);
      check({tag, " s_state"}, s_state, 0);
   endtask

   initial begin
      //         ce clr en ld data  q   | err exp  st cnt  state fexp fobs
      tbl[0]  = mk(1, 0, 1, 0, 4'h0, 4'h2, 0, 4'h3, 0, 8'd0, 2'b01, 4'h0, 4'h0);
      tbl[1]  = mk(1, 0, 1, 1, 4'hA, 4'h3, 0, 4'hA, 0, 8'd0, 2'b01, 4'h0, 4'h0);
      tbl[2]  = mk(1, 0, 1, 0, 4'h0, 4'hA, 0, 4'hB, 0, 8'd0, 2'b01, 4'h0, 4'h0);
      tbl[3]  = mk(1, 0, 0, 0, 4'h0, 4'hB, 0, 4'hB, 0, 8'd0, 2'b01, 4'h0, 4'h0);
      tbl[4]  = mk(1, 0, 1, 0, 4'h0, 4'hB, 0, 4'hC, 0, 8'd0, 2'b01, 4'h0, 4'h0);
      tbl[5]  = mk(1, 0, 1, 1, 4'hF, 4'hC, 0, 4'hF, 0, 8'd0, 2'b01, 4'h0, 4'h0);
      tbl[6]  = mk(1, 0, 1, 0, 4'h0, 4'hF, 0, 4'h0, 0, 8'd0, 2'b01, 4'h0, 4'h0);
      tbl[7]  = mk(1, 0, 1, 0, 4'h0, 4'h0, 0, 4'h1, 0, 8'd0, 2'b01, 4'h0, 4'h0);
      tbl[8]  = mk(1, 0, 1, 0, 4'h0, 4'h1, 0, 4'h2, 0, 8'd0, 2'b01, 4'h0, 4'h0);
      tbl[9]  = mk(1, 0, 1, 0, 4'h0, 4'h2, 0, 4'h3, 0, 8'd0, 2'b01, 4'h0, 4'h0);
      tbl[10] = mk(1, 0, 1, 0, 4'h0, 4'h5, 1, 4'h6, 1, 8'd1, 2'b01, 4'h3, 4'h5);
      tbl[11] = mk(1, 0, 1, 0, 4'h0, 4'h6, 0, 4'h7, 1, 8'd1, 2'b01, 4'h3, 4'h5);
      tbl[12] = mk(1, 0, 1, 0, 4'h0, 4'h9, 1, 4'hA, 1, 8'd2, 2'b01, 4'h3, 4'h5);
      tbl[13] = mk(1, 0, 1, 0, 4'h0, 4'hA, 0, 4'hB, 1, 8'd2, 2'b01, 4'h3, 4'h5);
      tbl[14] = mk(0, 0, 1, 0, 4'h0, 4'hB, 0, 4'hC, 1, 8'd2, 2'b00, 4'h3, 4'h5);
      tbl[15] = mk(0, 0, 0, 0, 4'h0, 4'h7, 0, 4'h7, 1, 8'd2, 2'b00, 4'h3, 4'h5);
      tbl[16] = mk(1, 0, 1, 0, 4'h0, 4'h3, 0, 4'h4, 1, 8'd2, 2'b01, 4'h3, 4'h5);
      tbl[17] = mk(1, 0, 1, 0, 4'h0, 4'h9, 1, 4'hA, 1, 8'd3, 2'b01, 4'h3, 4'h5);
      tbl[18] = mk(1, 1, 1, 0, 4'h0, 4'h4, 0, 4'h5, 0, 8'd0, 2'b00, 4'h0, 4'h0);
      tbl[19] = mk(1, 0, 1, 0, 4'h0, 4'h9, 0, 4'hA, 0, 8'd0, 2'b01, 4'h0, 4'h0);
      tbl[20] = mk(1, 0, 1, 0, 4'h0, 4'hA, 0, 4'hB, 0, 8'd0, 2'b01, 4'h0, 4'h0);

      rst_n = 1'b0;
      drive(0, 0, 0, 0, 4'h0, 4'h0);
      #30;
      check_all_zero("reset");
      #5;
      rst_n = 1'b1;

      // Correct counter running 0..15,0,1 with checking enabled.
      drive(1, 0, 1, 0, 4'h0, 4'h0);
      for (int i = 0; i < 18; i++) begin
         logic [3:0] q_now;
         q_now = cnt_q;
         edge_sample();
         check("run state",   state,   2'b01);
         check("run err",     err,     0);
         check("run sticky",  sticky,  0);
         check("run err_cnt", err_cnt, 0);
         check("run exp",     exp_v,   4'(q_now + 4'd1));
         cnt_q = q_now + 4'd1;
      end

      for (int i = 0; i < 21; i++) begin
         drive(tbl[i].ce, tbl[i].clr, tbl[i].en, tbl[i].ld, tbl[i].data, tbl[i].q);
         edge_sample();
         check($sformatf("vec%0d err", i),     err,     tbl[i].err);
         check($sformatf("vec%0d exp", i),     exp_v,   tbl[i].exp_v);
         check($sformatf("vec%0d sticky", i),  sticky,  tbl[i].sticky);
         check($sformatf("vec%0d err_cnt", i), err_cnt, tbl[i].cnt);
         check($sformatf("vec%0d state", i),   state,   tbl[i].state);
         check($sformatf("vec%0d fexp", i),    fexp,    tbl[i].fexp);
         check($sformatf("vec%0d fobs", i),    fobs,    tbl[i].fobs);
      end

      // 300 back-to-back mismatches: count saturates, first-error capture holds.
      for (int i = 0; i < 300; i++) begin
         drive(1, 0, 0, 0, 4'h0, (i % 2 == 1) ? 4'h6 : 4'h5);
         edge_sample();
         check("sat err",     err,     1);
         check("sat err_cnt", err_cnt, (i < 255) ? i + 1 : 255);
      end
      check("sat sticky", sticky, 1);
      check("sat fexp",   fexp,   4'hB);
      check("sat fobs",   fobs,   4'h5);

      // Build err_cnt=2 in TRACK, then assert reset between edges.
      drive(0, 1, 0, 0, 4'h0, 4'h0);
      edge_sample();
      check("clr err_cnt", err_cnt, 0);
      drive(1, 0, 0, 0, 4'h0, 4'h0);
      edge_sample();
      drive(1, 0, 0, 0, 4'h0, 4'h1);
      edge_sample();
      drive(1, 0, 0, 0, 4'h0, 4'h2);
      edge_sample();
      check("pre-rst err_cnt", err_cnt, 2);
      check("pre-rst state",   state,   2'b01);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("async rst");
      @(negedge clk);
      rst_n = 1'b1;

      // Resume from IDLE after release; then stop-on-error behaviour.
      drive(1, 0, 1, 0, 4'h0, 4'h4);
      edge_sample();
      check("resume state", state, 2'b01);
      check("resume exp",   exp_v, 4'h5);
      check("resume err",   err,   0);
      drive(1, 0, 1, 0, 4'h0, 4'h5);
      edge_sample();
      check("stop pre state", s_state, 2'b01);
      check("stop pre exp",   s_exp,   4'h6);
      drive(1, 0, 1, 0, 4'h0, 4'h9);
      edge_sample();
      check("stop state",   s_state,   2'b10);
      check("stop err",     s_err,     1);
      check("stop err_cnt", s_err_cnt, 1);
      check("stop fexp",    s_fexp,    4'h6);
      check("stop fobs",    s_fobs,    4'h9);
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 1, 0, 4'h0, 4'h3 + 4'(i));
         edge_sample();
         check("fault state",   s_state,   2'b10);
         check("fault err",     s_err,     0);
         check("fault err_cnt", s_err_cnt, 1);
         check("fault exp",     s_exp,     4'hA);
         check("fault fobs",    s_fobs,    4'h9);
      end
      drive(1, 1, 1, 0, 4'h0, 4'h7);
      edge_sample();
      check("stop clr state",   s_state,   2'b00);
      check("stop clr err",     s_err,     0);
      check("stop clr sticky",  s_sticky,  0);
      check("stop clr err_cnt", s_err_cnt, 0);
      check("stop clr fexp",    s_fexp,    0);
      check("stop clr fobs",    s_fobs,    0);
      check("stop clr exp",     s_exp,     4'h8);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/counter_checker.md
COUNTER_CHECKER -- requirements
Module: counter_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning observed counter width in bits.
REQ-002 SHALL have parameter ERR_CNT_W, default 8, meaning width of the saturating error counter.
REQ-003 SHALL have parameter STOP_ON_ERR, default 0, meaning 1 = halt checking in FAULT after first mismatch.
REQ-004 SHALL use one clock and an asynchronous, active-low reset: clk_i  input  1  clock, rising edge.
REQ-005 SHALL provide rst_n_i  input  1  asynchronous active-low reset.
REQ-006 SHALL provide check_en_i  input  1  enable comparison; 0 = follow-only.
REQ-007 SHALL provide clear_i  input  1  synchronous clear of error status and return to IDLE.
REQ-008 SHALL provide cnt_en_i  input  1  observed counter increment enable.
REQ-009 SHALL provide cnt_load_i  input  1  observed counter parallel-load strobe.
REQ-010 SHALL provide cnt_data_i  input  WIDTH  observed counter load value.
REQ-011 SHALL provide cnt_q_i  input  WIDTH  observed counter output.
REQ-012 SHALL provide err_o  output  1  one-cycle mismatch pulse.
REQ-013 SHALL provide err_sticky_o  output  1  set on any mismatch, held until clear_i or reset.
REQ-014 SHALL provide err_cnt_o  output  ERR_CNT_W  saturating mismatch count.
REQ-015 SHALL provide exp_o  output  WIDTH  current expected counter value.
REQ-016 SHALL provide first_err_exp_o / first_err_obs_o  output  WIDTH each  expected/observed values at first mismatch.
REQ-017 SHALL provide state_o  output  2  FSM state: 00 IDLE, 01 TRACK, 10 FAULT.

Function
REQ-018 Reference model SHALL be next(q) = cnt_data_i if cnt_load_i; else q+1 mod 2^WIDTH if cnt_en_i; else q (load has priority over enable).
REQ-019 On every edge not in FAULT, exp register SHALL load next(cnt_q_i) using controls sampled at that edge (resync to observed, so a single fault yields a single error).
REQ-020 In TRACK, at each edge the checker SHALL compare cnt_q_i with exp register; mismatch registers err_o=1 for exactly one cycle (latency: one edge after the bad value is sampled).
REQ-021 IDLE SHALL perform no comparison; IDLE -> TRACK on edge with check_en_i=1 (first comparison at the following edge).
REQ-022 TRACK -> IDLE on edge with check_en_i=0; no comparison at that edge.
REQ-023 TRACK -> FAULT on mismatch only when STOP_ON_ERR=1; with STOP_ON_ERR=0 remain in TRACK.
REQ-024 FAULT SHALL freeze exp, err_cnt and first-error registers, keep err_o=0; exit only via clear_i or reset.
REQ-025 Each mismatch SHALL increment err_cnt_o by 1, saturating at 2^ERR_CNT_W-1 with no wrap.
REQ-026 first_err_exp_o/first_err_obs_o SHALL capture only when err_sticky_o is 0 at the mismatch edge.
REQ-027 clear_i SHALL have priority over comparison: at that edge clear err_o, err_sticky_o, err_cnt_o, first-error registers, go to IDLE, exp loads next(cnt_q_i).
REQ-028 Wrap-around 2^WIDTH-1 -> 0 with cnt_en_i=1 SHALL be a match, not an error.

Reset
REQ-029 While rst_n_i=0, immediately and asynchronously: state IDLE, exp_o=0, err_o=0, err_sticky_o=0, err_cnt_o=0, first_err_*_o=0.
REQ-030 Reset asserted mid-operation (any state, including FAULT) SHALL discard all status; operation resumes from IDLE on first edge after release.

Verification
REQ-031 Reset held 35 ns, 10 ns clock, check_en_i=1, cnt_en_i=1, correct 4-bit counter -> q 0..15,0,1; err_cnt_o=0, err_sticky_o=0, state_o=01.
REQ-032 cnt_load_i=1 and cnt_en_i=1, cnt_data_i=4'hA while q=3 -> exp_o=A, counter shows A, no error.
REQ-033 Force cnt_q_i=5 when exp_o=3 -> err_o one-cycle pulse, err_sticky_o=1, err_cnt_o=1, first_err_exp_o=3, first_err_obs_o=5; next cycle exp_o=6, no further error.
REQ-034 300 consecutive mismatches, ERR_CNT_W=8 -> err_cnt_o stops at 255; first_err_* unchanged after first.
REQ-035 STOP_ON_ERR=1, one mismatch -> state_o=10, later mismatches not counted; clear_i pulse -> state_o=00, all error outputs 0.
REQ-036 rst_n_i pulled low mid-count in TRACK with err_cnt_o=2 -> all outputs to REQ-029 values before next clock edge.
